// File: rtl/tlul_protocol_monitor.sv
// Passive TL-UL link monitor: tracks in-flight requests by source ID and raises
// sticky protocol-violation flags, a registered interrupt and an outstanding count.
module tlul_protocol_monitor #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int AIW            = 8,
    parameter int SZW            = 2,
    parameter int MaxOutstanding = 4,
    localparam int DBW  = DW / 8,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            a_valid_i,
    input  logic            a_ready_i,
    input  logic [2:0]      a_opcode_i,
    input  logic [SZW-1:0]  a_size_i,
    input  logic [AIW-1:0]  a_source_i,
    input  logic [AW-1:0]   a_address_i,
    input  logic [DBW-1:0]  a_mask_i,
    input  logic            d_valid_i,
    input  logic            d_ready_i,
    input  logic [2:0]      d_opcode_i,
    input  logic [SZW-1:0]  d_size_i,
    input  logic [AIW-1:0]  d_source_i,
    input  logic            clr_i,
    output logic [7:0]      err_o,
    output logic            err_irq_o,
    output logic [CntW-1:0] outstanding_o
);
    localparam int OffW  = (DBW > 1) ? $clog2(DBW) : 1;
    localparam int IdxW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int SzMax = $clog2(DBW);
    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpPutPartial    = 3'd1;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    logic [MaxOutstanding-1:0] valid_q, valid_d, get_q, get_d;
    logic [AIW-1:0]            src_q  [MaxOutstanding];
    logic [AIW-1:0]            src_d  [MaxOutstanding];
    logic [SZW-1:0]            size_q [MaxOutstanding];
    logic [SZW-1:0]            size_d [MaxOutstanding];
    logic [7:0]                err_q, err_d;
    logic                      irq_q, irq_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      a_stall_q, a_stall_d, d_stall_q, d_stall_d;
    logic [2:0]                a_op_q, a_op_d, d_op_q, d_op_d;
    logic [SZW-1:0]            a_size_q, a_size_d, d_size_q, d_size_d;
    logic [AIW-1:0]            a_src_q, a_src_d, d_src_q, d_src_d;
    logic [AW-1:0]             a_addr_q, a_addr_d;
    logic [DBW-1:0]            a_mask_q, a_mask_d;

    logic                      a_fire_s, d_fire_s, d_hit_s, d_rel_s;
    logic                      a_dup_s, a_full_s, a_alloc_s;
    logic [IdxW-1:0]           d_idx_s, free_idx_s;
    logic [MaxOutstanding-1:0] d_match_s, valid_rel_s, a_match_s, alloc_sel_s;
    logic [DBW-1:0]            lane_pat_s;
    logic                      a_op_legal_s, a_size_bad_s, a_misalign_s, a_mask_bad_s;
    logic                      a_chg_s, d_chg_s;
    logic [2:0]                exp_op_s;
    logic [7:0]                new_err_s;
    int                        off_s, bytes_s;

    // Request encoding legality: opcode, size, alignment and byte-lane mask.
    always_comb begin
        a_op_legal_s = (a_opcode_i == OpPutFull) || (a_opcode_i == OpPutPartial) ||
                       (a_opcode_i == OpGet);
        a_size_bad_s = int'(a_size_i) > SzMax;
        off_s        = int'(a_address_i[OffW-1:0]);
        bytes_s      = int'(32'd1 << a_size_i);
        a_misalign_s = (off_s & (bytes_s - 32'sd1)) != 32'sd0;
        lane_pat_s   = '0;
        for (int b = 0; b < DBW; b++) begin
            lane_pat_s[b] = (b >= off_s) && (b < (off_s + bytes_s));
        end
        case (a_opcode_i)
            OpPutFull, OpGet: a_mask_bad_s = (a_mask_i != lane_pat_s);
            OpPutPartial:     a_mask_bad_s = (a_mask_i == '0) || ((a_mask_i & ~lane_pat_s) != '0);
            default:          a_mask_bad_s = 1'b0;
        endcase
    end

    // Pending table: D lookup on the old table, A checks/allocation on the post-release table.
    always_comb begin
        a_fire_s    = a_valid_i & a_ready_i;
        d_fire_s    = d_valid_i & d_ready_i;
        d_match_s   = '0;
        valid_rel_s = '0;
        a_match_s   = '0;
        alloc_sel_s = '0;
        d_idx_s     = '0;
        free_idx_s  = '0;
        valid_d     = '0;
        get_d       = get_q;
        src_d       = src_q;
        size_d      = size_q;
        cnt_d       = '0;
        for (int i = MaxOutstanding - 1; i >= 0; i--) begin
            d_match_s[i] = valid_q[i] && (src_q[i] == d_source_i);
            d_idx_s      = d_match_s[i] ? IdxW'(i) : d_idx_s;
        end
        d_hit_s = |d_match_s;
        d_rel_s = d_fire_s & d_hit_s;
        for (int i = 0; i < MaxOutstanding; i++) begin
            valid_rel_s[i] = valid_q[i] & ~(d_rel_s && (d_idx_s == IdxW'(i)));
            a_match_s[i]   = valid_rel_s[i] && (src_q[i] == a_source_i);
        end
        a_dup_s  = |a_match_s;
        a_full_s = &valid_rel_s;
        for (int i = MaxOutstanding - 1; i >= 0; i--) begin
            free_idx_s = valid_rel_s[i] ? free_idx_s : IdxW'(i);
        end
        a_alloc_s = a_fire_s & ~a_dup_s & ~a_full_s;
        for (int i = 0; i < MaxOutstanding; i++) begin
            alloc_sel_s[i] = a_alloc_s && (free_idx_s == IdxW'(i));
            valid_d[i]     = valid_rel_s[i] | alloc_sel_s[i];
            get_d[i]       = alloc_sel_s[i] ? (a_opcode_i == OpGet) : get_q[i];
            src_d[i]       = alloc_sel_s[i] ? a_source_i : src_q[i];
            size_d[i]      = alloc_sel_s[i] ? a_size_i : size_q[i];
            cnt_d          = cnt_d + CntW'(valid_d[i]);
        end
    end

    // Error detection, sticky flag update and stall-tracker capture.
    always_comb begin
        exp_op_s = get_q[d_idx_s] ? OpAccessAckData : OpAccessAck;
        a_chg_s  = (a_opcode_i != a_op_q) || (a_size_i != a_size_q) ||
                   (a_source_i != a_src_q) || (a_address_i != a_addr_q) ||
                   (a_mask_i != a_mask_q);
        d_chg_s  = (d_opcode_i != d_op_q) || (d_size_i != d_size_q) ||
                   (d_source_i != d_src_q);
        new_err_s    = 8'h00;
        new_err_s[0] = a_fire_s & ~a_op_legal_s;
        new_err_s[1] = a_fire_s & (a_size_bad_s | a_misalign_s | a_mask_bad_s);
        new_err_s[2] = a_fire_s & a_dup_s;
        new_err_s[3] = a_fire_s & ~a_dup_s & a_full_s;
        new_err_s[4] = d_fire_s & ~d_hit_s;
        new_err_s[5] = d_rel_s & ((d_opcode_i != exp_op_s) || (d_size_i != size_q[d_idx_s]));
        new_err_s[6] = a_stall_q & (~a_valid_i | a_chg_s);
        new_err_s[7] = d_stall_q & (~d_valid_i | d_chg_s);
        err_d     = (clr_i ? 8'h00 : err_q) | new_err_s;
        irq_d     = |err_q;
        a_stall_d = a_valid_i & ~a_ready_i;
        d_stall_d = d_valid_i & ~d_ready_i;
        a_op_d    = a_opcode_i;
        a_size_d  = a_size_i;
        a_src_d   = a_source_i;
        a_addr_d  = a_address_i;
        a_mask_d  = a_mask_i;
        d_op_d    = d_opcode_i;
        d_size_d  = d_size_i;
        d_src_d   = d_source_i;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            get_q     <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                src_q[i]  <= '0;
                size_q[i] <= '0;
            end
            err_q     <= 8'h00;
            irq_q     <= 1'b0;
            cnt_q     <= '0;
            a_stall_q <= 1'b0;
            d_stall_q <= 1'b0;
            a_op_q    <= 3'd0;
            a_size_q  <= '0;
            a_src_q   <= '0;
            a_addr_q  <= '0;
            a_mask_q  <= '0;
            d_op_q    <= 3'd0;
            d_size_q  <= '0;
            d_src_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            get_q     <= get_d;
            src_q     <= src_d;
            size_q    <= size_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            cnt_q     <= cnt_d;
            a_stall_q <= a_stall_d;
            d_stall_q <= d_stall_d;
            a_op_q    <= a_op_d;
            a_size_q  <= a_size_d;
            a_src_q   <= a_src_d;
            a_addr_q  <= a_addr_d;
            a_mask_q  <= a_mask_d;
            d_op_q    <= d_op_d;
            d_size_q  <= d_size_d;
            d_src_q   <= d_src_d;
        end
    end

    assign err_o         = err_q;
    assign err_irq_o     = irq_q;
    assign outstanding_o = cnt_q;
endmodule

// File: tb/tb_tlul_protocol_monitor.sv
// Scoreboard bench for tlul_protocol_monitor: directed scenarios then random traffic,
// checked against a transaction-level model keyed by source ID.
module tb_tlul_protocol_monitor;
    localparam int AW = 32, DW = 32, AIW = 8, SZW = 2, MO = 4;
    localparam int DBW = DW / 8;
    localparam int CW  = $clog2(MO + 1);

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic           rst_i, clr_i;
    logic           a_valid_i, a_ready_i, d_valid_i, d_ready_i;
    logic [2:0]     a_opcode_i, d_opcode_i;
    logic [SZW-1:0] a_size_i, d_size_i;
    logic [AIW-1:0] a_source_i, d_source_i;
    logic [AW-1:0]  a_address_i;
    logic [DBW-1:0] a_mask_i;
    logic [7:0]     err_o;
    logic           err_irq_o;
    logic [CW-1:0]  outstanding_o;

    tlul_protocol_monitor #(.AW(AW), .DW(DW), .AIW(AIW), .SZW(SZW), .MaxOutstanding(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_ready_i(a_ready_i), .a_opcode_i(a_opcode_i),
        .a_size_i(a_size_i), .a_source_i(a_source_i), .a_address_i(a_address_i),
        .a_mask_i(a_mask_i),
        .d_valid_i(d_valid_i), .d_ready_i(d_ready_i), .d_opcode_i(d_opcode_i),
        .d_size_i(d_size_i), .d_source_i(d_source_i),
        .clr_i(clr_i), .err_o(err_o), .err_irq_o(err_irq_o), .outstanding_o(outstanding_o)
    );

    typedef struct packed {
        logic [7:0]    err;
        logic          irq;
        logic [CW-1:0] outs;
    } exp_t;
    typedef struct packed {
        logic           is_get;
        logic [SZW-1:0] size;
    } ent_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    ent_t           pend[int];
    logic [7:0]     m_err = 8'h00;
    logic           p_as = 1'b0, p_ds = 1'b0;
    logic [2:0]     p_aop, p_dop;
    logic [SZW-1:0] p_asz, p_dsz;
    logic [AIW-1:0] p_asrc, p_dsrc;
    logic [AW-1:0]  p_addr;
    logic [DBW-1:0] p_mask;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("err_o", 32'(err_o), 32'(mon_e.err));
            chk("err_irq_o", 32'(err_irq_o), 32'(mon_e.irq));
            chk("outstanding_o", 32'(outstanding_o), 32'(mon_e.outs));
        end
    end

    // Evaluate the protocol rules on the current inputs, queue the expectation, advance a cycle.
    task automatic step();
        logic [7:0] nerr;
        exp_t       e;
        ent_t       ent;
        int         bytes, lo, pat, op;
        nerr = 8'h00;
        if (rst_i) begin
            pend.delete();
            m_err = 8'h00;
            e = '{err: 8'h00, irq: 1'b0, outs: '0};
            p_as = 1'b0;
            p_ds = 1'b0;
        end else begin
            if (d_valid_i && d_ready_i) begin
                if (pend.exists(int'(d_source_i))) begin
                    ent = pend[int'(d_source_i)];
                    if (d_opcode_i != (ent.is_get ? 3'd1 : 3'd0) || d_size_i != ent.size) nerr[5] = 1'b1;
                    pend.delete(int'(d_source_i));
                end else begin
                    nerr[4] = 1'b1;
                end
            end
            if (a_valid_i && a_ready_i) begin
                op = int'(a_opcode_i);
                if (!(op == 0 || op == 1 || op == 4)) nerr[0] = 1'b1;
                bytes = 1 << a_size_i;
                lo    = int'(a_address_i % 32'(DBW));
                pat   = (((1 << bytes) - 1) << lo) & ((1 << DBW) - 1);
                if (int'(a_size_i) > $clog2(DBW) || (a_address_i % 32'(bytes)) != 0) nerr[1] = 1'b1;
                if ((op == 0 || op == 4) && int'(a_mask_i) != pat) nerr[1] = 1'b1;
                if (op == 1 && (a_mask_i == 0 || (int'(a_mask_i) & ~pat) != 0)) nerr[1] = 1'b1;
                if (pend.exists(int'(a_source_i))) nerr[2] = 1'b1;
                else if (pend.num() >= MO) nerr[3] = 1'b1;
                else pend[int'(a_source_i)] = '{is_get: (op == 4), size: a_size_i};
            end
            if (p_as && (!a_valid_i || a_opcode_i != p_aop || a_size_i != p_asz ||
                         a_source_i != p_asrc || a_address_i != p_addr || a_mask_i != p_mask))
                nerr[6] = 1'b1;
            if (p_ds && (!d_valid_i || d_opcode_i != p_dop || d_size_i != p_dsz || d_source_i != p_dsrc))
                nerr[7] = 1'b1;
            e.irq  = |m_err;
            m_err  = (clr_i ? 8'h00 : m_err) | nerr;
            e.err  = m_err;
            e.outs = CW'(pend.num());
            p_as   = a_valid_i & ~a_ready_i;
            p_ds   = d_valid_i & ~d_ready_i;
        end
        p_aop = a_opcode_i; p_asz = a_size_i; p_asrc = a_source_i; p_addr = a_address_i; p_mask = a_mask_i;
        p_dop = d_opcode_i; p_dsz = d_size_i; p_dsrc = d_source_i;
        exp_q.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic set_a(logic v, logic r, logic [2:0] op, logic [SZW-1:0] sz, logic [AIW-1:0] src,
                         logic [AW-1:0] addr, logic [DBW-1:0] m);
        a_valid_i = v; a_ready_i = r; a_opcode_i = op; a_size_i = sz;
        a_source_i = src; a_address_i = addr; a_mask_i = m;
    endtask

    task automatic set_d(logic v, logic r, logic [2:0] op, logic [SZW-1:0] sz, logic [AIW-1:0] src);
        d_valid_i = v; d_ready_i = r; d_opcode_i = op; d_size_i = sz; d_source_i = src;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 4'h0);
        set_d(1'b0, 1'b0, 3'd0, 2'd0, 8'd0);
    endtask

    task automatic rand_cycle();
        int r, keys[$], off, bytes, pat;
        rst_i = ($urandom_range(0, 299) == 0);
        clr_i = ($urandom_range(0, 19) == 0);
        if (p_as && $urandom_range(0, 19) != 0) begin
            a_valid_i = 1'b1;
        end else begin
            a_valid_i = ($urandom_range(0, 1) == 1);
            r = int'($urandom_range(0, 19));
            a_opcode_i = (r == 0) ? 3'($urandom_range(0, 7)) : (r < 8 ? 3'd4 : (r < 14 ? 3'd0 : 3'd1));
            a_size_i   = ($urandom_range(0, 19) == 0) ? 2'd3 : SZW'($urandom_range(0, 2));
            a_source_i = AIW'($urandom_range(0, 7));
            bytes = 1 << a_size_i;
            off   = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) != 0) off = off & ~(bytes - 1);
            a_address_i = (32'($urandom_range(0, 63)) << 2) + 32'(off);
            pat = (((1 << bytes) - 1) << off) & 15;
            if ($urandom_range(0, 9) == 0) a_mask_i = DBW'($urandom_range(0, 15));
            else if (a_opcode_i == 3'd1) a_mask_i = DBW'(pat & int'($urandom_range(1, 15)));
            else a_mask_i = DBW'(pat);
        end
        a_ready_i = ($urandom_range(0, 9) < 6);
        if (p_ds && $urandom_range(0, 19) != 0) begin
            d_valid_i = 1'b1;
        end else begin
            d_valid_i = ($urandom_range(0, 9) < 4);
            foreach (pend[k]) keys.push_back(k);
            if (keys.size() > 0 && $urandom_range(0, 9) != 0) begin
                r = keys[$urandom_range(0, keys.size() - 1)];
                d_source_i = AIW'(r);
                d_opcode_i = pend[r].is_get ? 3'd1 : 3'd0;
                d_size_i   = pend[r].size;
                if ($urandom_range(0, 9) == 0) d_opcode_i = 3'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) d_size_i = SZW'($urandom_range(0, 3));
            end else begin
                d_source_i = AIW'($urandom_range(0, 15));
                d_opcode_i = 3'($urandom_range(0, 1));
                d_size_i   = SZW'($urandom_range(0, 2));
            end
        end
        d_ready_i = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; idle();
        step(); step();
        rst_i = 1'b0;
        // single Get and its AccessAckData
        set_a(1'b1, 1'b1, 3'd4, 2'd2, 8'd5, 32'h10, 4'hF); step();
        idle(); set_d(1'b1, 1'b1, 3'd1, 2'd2, 8'd5); step();
        idle(); step();
        // fill the table, then overflow
        for (int s = 0; s < 4; s++) begin
            set_a(1'b1, 1'b1, 3'd4, 2'd2, AIW'(s), 32'(s * 16), 4'hF); step();
        end
        set_a(1'b1, 1'b1, 3'd4, 2'd2, 8'd4, 32'h40, 4'hF); step();
        idle(); step();
        // reissue src 2 in the cycle its response fires while full
        set_a(1'b1, 1'b1, 3'd0, 2'd2, 8'd2, 32'h20, 4'hF); set_d(1'b1, 1'b1, 3'd1, 2'd2, 8'd2); step();
        idle(); clr_i = 1'b1; step(); clr_i = 1'b0;
        // unexpected response, then clear
        set_d(1'b1, 1'b1, 3'd0, 2'd2, 8'd9); step();
        idle(); step();
        clr_i = 1'b1; step(); clr_i = 1'b0; step(); step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        // misaligned Get, empty PutPartial mask, Get answered by AccessAck
        set_a(1'b1, 1'b1, 3'd4, 2'd2, 8'd1, 32'h2, 4'hF); step();
        set_a(1'b1, 1'b1, 3'd1, 2'd2, 8'd6, 32'h20, 4'h0); step();
        set_a(1'b1, 1'b1, 3'd4, 2'd2, 8'd7, 32'h30, 4'hF); step();
        idle(); set_d(1'b1, 1'b1, 3'd0, 2'd2, 8'd7); step();
        idle(); clr_i = 1'b1; step(); clr_i = 1'b0;
        // stalled A changes address, then reset mid-burst
        set_a(1'b1, 1'b0, 3'd4, 2'd2, 8'd3, 32'h10, 4'hF); step();
        set_a(1'b1, 1'b0, 3'd4, 2'd2, 8'd3, 32'h14, 4'hF); step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        idle(); step(); step();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_cycle(); step();
        end
        rst_i = 1'b0; clr_i = 1'b0; idle(); step(); step();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
